// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage, the execute stage and the ROM tables.
// Holds the opcode map, instruction field positions and fetch FSM states.
package instr_fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_INST_W = 16;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned REG_W      = 3;
    localparam int unsigned IMM_W      = 8;
    localparam int unsigned TGT_W      = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_LOAD = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUBI = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1000;
    localparam logic [OP_W-1:0] OP_BR   = 4'b1100;
    localparam logic [OP_W-1:0] OP_MOV  = 4'b1110;
    localparam logic [OP_W-1:0] OP_OUT  = 4'b1111;

    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 9;
    localparam int unsigned RS_HI  = 8;
    localparam int unsigned RS_LO  = 6;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned TGT_HI = 11;
    localparam int unsigned TGT_LO = 8;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } fetch_state_e;

    // Decoded fields handed to execute.
    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [IMM_W-1:0] imm;
    } dec_fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational instruction splitter: raw ROM word to fields, jump/branch
// target and control-flow flags.
module instr_field_split
    import instr_fetch_pkg::*;
(
    input  logic [DEF_INST_W-1:0] inst_i,
    output dec_fields_t           fields_o,
    output logic [TGT_W-1:0]      tgt_o,
    output logic                  is_jmp_o,
    output logic                  is_br_o,
    output logic                  is_nop_o
);

    always_comb begin
        fields_o.opcode = inst_i[OP_HI:OP_LO];
        fields_o.rd     = inst_i[RD_HI:RD_LO];
        fields_o.rs     = inst_i[RS_HI:RS_LO];
        fields_o.imm    = inst_i[IMM_HI:IMM_LO];
        tgt_o           = inst_i[TGT_HI:TGT_LO];
        is_jmp_o        = (inst_i[OP_HI:OP_LO] == OP_JMP);
        is_br_o         = (inst_i[OP_HI:OP_LO] == OP_BR);
        is_nop_o        = (inst_i[OP_HI:OP_LO] == OP_NOP);
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the program ROM, resolves jumps locally and
// stalls on conditional branches until execute reports the outcome.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INST_W   = DEF_INST_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [OP_W-1:0]   dec_opcode,
    output logic [REG_W-1:0]  dec_rd,
    output logic [REG_W-1:0]  dec_rs,
    output logic [IMM_W-1:0]  dec_imm,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              br_done,
    input  logic              br_taken
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
    logic              dec_valid_q, dec_valid_d;
    dec_fields_t       dec_q, dec_d;

    dec_fields_t       fields;
    logic [TGT_W-1:0]  tgt;
    logic              is_jmp;
    logic              is_br;
    logic              is_nop;
    logic              slot_free;

    instr_field_split u_split (
        .inst_i   (rom_data),
        .fields_o (fields),
        .tgt_o    (tgt),
        .is_jmp_o (is_jmp),
        .is_br_o  (is_br),
        .is_nop_o (is_nop)
    );

    assign slot_free = !dec_valid_q || dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= ADDR_W'(RESET_PC);
            br_tgt_q    <= '0;
            dec_pc_q    <= '0;
            dec_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_tgt_q    <= br_tgt_d;
            dec_pc_q    <= dec_pc_d;
            dec_valid_q <= dec_valid_d;
            dec_q       <= dec_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_tgt_d    = br_tgt_q;
        dec_pc_d    = dec_pc_q;
        dec_valid_d = dec_valid_q;
        dec_d       = dec_q;
        case (state_q)
            ST_RUN: begin
                if (slot_free) begin
                    if (is_jmp) begin
                        pc_d        = ADDR_W'(tgt);
                        dec_valid_d = 1'b0;
                    end else if (is_nop) begin
                        pc_d        = pc_q + ADDR_W'(1);
                        dec_valid_d = 1'b0;
                    end else begin
                        dec_valid_d = 1'b1;
                        dec_d       = fields;
                        dec_pc_d    = pc_q;
                        pc_d        = pc_q + ADDR_W'(1);
                        if (is_br) begin
                            br_tgt_d = ADDR_W'(tgt);
                            state_d  = ST_BR_WAIT;
                        end
                    end
                end
            end
            ST_BR_WAIT: begin
                // pc already points past the br, so not-taken needs no update.
                if (dec_valid_q && dec_ready) begin
                    dec_valid_d = 1'b0;
                end
                if (br_done) begin
                    if (br_taken) begin
                        pc_d = br_tgt_q;
                    end
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign rom_addr   = pc_q;
    assign dec_valid  = dec_valid_q;
    assign dec_opcode = dec_q.opcode;
    assign dec_rd     = dec_q.rd;
    assign dec_rs     = dec_q.rs;
    assign dec_imm    = dec_q.imm;
    assign dec_pc     = dec_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing scenarios plus randomized programs
// checked against an instruction-level program model through a scoreboard.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_opcode;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_rs;
    logic [7:0]  dec_imm;
    logic [3:0]  dec_pc;
    logic        br_done;
    logic        br_taken;

    logic [15:0] rom [16];

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        logic [3:0] pc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_sb     = 0;
    logic       sb_en    = 1'b0;
    logic [3:0] m_pc;
    logic [3:0] m_tgt;
    logic       m_wait;
    logic       m_dead;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    instr_fetch #(.ADDR_W(4), .INST_W(16), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_opcode(dec_opcode),
        .dec_rd    (dec_rd),
        .dec_rs    (dec_rs),
        .dec_imm   (dec_imm),
        .dec_pc    (dec_pc),
        .br_done   (br_done),
        .br_taken  (br_taken)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dec(input string name, input logic [3:0] op, input logic [2:0] rd,
                           input logic [7:0] imm, input logic [3:0] pc);
        chk({name, "_valid"}, 32'(dec_valid), 32'd1);
        chk({name, "_op"},    32'(dec_opcode), 32'(op));
        chk({name, "_rd"},    32'(dec_rd), 32'(rd));
        chk({name, "_imm"},   32'(dec_imm), 32'(imm));
        chk({name, "_pc"},    32'(dec_pc), 32'(pc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    // Leaves rst asserted just after a clock edge; caller releases it.
    task automatic do_reset();
        rst = 1'b1;
        br_done = 1'b0;
        br_taken = 1'b0;
        step();
        step();
    endtask

    // Program-level reference: walk the ROM, skipping jmp/nop, stopping at br.
    task automatic model_fill();
        int          idle;
        logic [15:0] w;
        exp_t        e;
        idle = 0;
        while (!m_wait && !m_dead && q.size() < 4) begin
            w = rom[m_pc];
            if (w[15:12] == 4'h8) begin
                m_pc = w[11:8];
                idle++;
            end else if (w[15:12] == 4'h0) begin
                m_pc = m_pc + 4'd1;
                idle++;
            end else begin
                e.op = w[15:12]; e.rd = w[11:9]; e.rs = w[8:6]; e.imm = w[7:0]; e.pc = m_pc;
                q.push_back(e);
                idle = 0;
                if (w[15:12] == 4'hC) begin
                    m_wait = 1'b1;
                    m_tgt  = w[11:8];
                end
                m_pc = m_pc + 4'd1;
            end
            if (idle > 40) m_dead = 1'b1;
        end
    endtask

    task automatic model_resolve(input logic taken);
        if (taken) m_pc = m_tgt;
        m_wait = 1'b0;
    endtask

    // Scoreboard monitor: every accepted instruction must match the model's next one.
    always @(negedge clk) begin
        if (sb_en && dec_valid && dec_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got op %0h pc %0h expected no issue", dec_opcode, dec_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                n_sb++;
                chk("sb_op",  32'(dec_opcode), 32'(e.op));
                chk("sb_rd",  32'(dec_rd),     32'(e.rd));
                chk("sb_rs",  32'(dec_rs),     32'(e.rs));
                chk("sb_imm", 32'(dec_imm),    32'(e.imm));
                chk("sb_pc",  32'(dec_pc),     32'(e.pc));
            end
        end
    end

    task automatic branch_case(input logic taken);
        fill_nop();
        rom[0] = 16'h8400; rom[4] = 16'hCA00; rom[5] = 16'h3000; rom[10] = 16'hF200;
        dec_ready = 1'b1;
        do_reset();
        rst = 1'b0;
        step();
        chk("br_jmp_addr", 32'(rom_addr), 32'd4);
        step();
        chk_dec("br_issue", 4'hC, 3'd5, 8'h00, 4'd4);
        chk("br_issue_addr", 32'(rom_addr), 32'd5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("br_wait_addr", 32'(rom_addr), 32'd5);
            chk("br_wait_valid", 32'(dec_valid), 32'd0);
        end
        br_done = 1'b1;
        br_taken = taken;
        step();
        br_done = 1'b0;
        br_taken = 1'b0;
        chk("br_resolve_addr", 32'(rom_addr), taken ? 32'd10 : 32'd5);
        chk("br_resolve_valid", 32'(dec_valid), 32'd0);
        step();
        if (taken) chk_dec("br_taken_next", 4'hF, 3'd1, 8'h00, 4'd10);
        else       chk_dec("br_fall_next", 4'h3, 3'd0, 8'h00, 4'd5);
    endtask

    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'h8, 4'hC, 4'hE, 4'hF, 4'h5};

    initial begin
        rst = 1'b1; dec_ready = 1'b0; br_done = 1'b0; br_taken = 1'b0;

        // Reset state and straight-line issue
        fill_nop();
        rom[0] = 16'h1201; rom[1] = 16'hB401;
        do_reset();
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_addr",  32'(rom_addr), 32'd0);
        chk("rst_op",    32'(dec_opcode), 32'd0);
        chk("rst_rd",    32'(dec_rd), 32'd0);
        chk("rst_rs",    32'(dec_rs), 32'd0);
        chk("rst_imm",   32'(dec_imm), 32'd0);
        chk("rst_pc",    32'(dec_pc), 32'd0);
        dec_ready = 1'b1;
        rst = 1'b0;
        step();
        chk_dec("line0", 4'h1, 3'd1, 8'h01, 4'd0);
        step();
        chk_dec("line1", 4'hB, 3'd2, 8'h01, 4'd1);

        // Backpressure holds everything stable
        fill_nop();
        rom[0] = 16'h1E07; rom[1] = 16'h2A40;
        dec_ready = 1'b0;
        do_reset();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_dec("hold", 4'h1, 3'd7, 8'h07, 4'd0);
            chk("hold_addr", 32'(rom_addr), 32'd1);
            step();
        end
        chk_dec("hold_end", 4'h1, 3'd7, 8'h07, 4'd0);
        dec_ready = 1'b1;
        step();
        chk_dec("hold_release", 4'h2, 3'd5, 8'h40, 4'd1);

        // Jump: one bubble, redirect next cycle
        fill_nop();
        rom[0] = 16'h8500; rom[5] = 16'h2000; rom[6] = 16'h8300; rom[3] = 16'h2200;
        do_reset();
        rst = 1'b0;
        step();
        step();
        chk_dec("jmp_pre", 4'h2, 3'd0, 8'h00, 4'd5);
        step();
        chk("jmp_addr",   32'(rom_addr), 32'd3);
        chk("jmp_bubble", 32'(dec_valid), 32'd0);
        step();
        chk_dec("jmp_tgt", 4'h2, 3'd1, 8'h00, 4'd3);

        // Conditional branch, taken and not taken
        branch_case(1'b1);
        branch_case(1'b0);

        // Wrap around through a nop
        fill_nop();
        rom[0] = 16'h1201; rom[1] = 16'h8E00; rom[14] = 16'h0000; rom[15] = 16'hFE00;
        dec_ready = 1'b1;
        do_reset();
        rst = 1'b0;
        step();
        chk_dec("wrap_first", 4'h1, 3'd1, 8'h01, 4'd0);
        step();
        chk("wrap_jmp", 32'(dec_valid), 32'd0);
        step();
        chk("wrap_nop", 32'(dec_valid), 32'd0);
        step();
        chk_dec("wrap_out", 4'hF, 3'd7, 8'h00, 4'd15);
        chk("wrap_addr", 32'(rom_addr), 32'd0);
        step();
        chk_dec("wrap_load", 4'h1, 3'd1, 8'h01, 4'd0);

        // Reset while waiting on a held branch; late br_done ignored
        fill_nop();
        rom[0] = 16'h8400; rom[4] = 16'hCA00; rom[10] = 16'hF200;
        dec_ready = 1'b0;
        do_reset();
        rst = 1'b0;
        step();
        step();
        chk("midrst_pre_valid", 32'(dec_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(dec_valid), 32'd0);
        chk("midrst_addr",  32'(rom_addr), 32'd0);
        rst = 1'b0;
        br_done = 1'b1;
        br_taken = 1'b1;
        step();
        br_done = 1'b0;
        br_taken = 1'b0;
        chk("late_done_addr", 32'(rom_addr), 32'd4);
        step();
        chk_dec("late_done_run", 4'hC, 3'd5, 8'h00, 4'd4);

        // Randomized programs against the program model
        for (int r = 0; r < 6; r++) begin
            sb_en = 1'b0;
            q.delete();
            for (int i = 0; i < 16; i++) begin
                rom[i] = {ops[$urandom_range(9, 0)], 12'($urandom)};
            end
            dec_ready = 1'b0;
            do_reset();
            m_pc = 4'd0; m_wait = 1'b0; m_dead = 1'b0;
            model_fill();
            sb_en = 1'b1;
            rst = 1'b0;
            for (int c = 0; c < 400; c++) begin
                br_done = 1'b0;
                br_taken = 1'b0;
                dec_ready = ($urandom_range(3, 0) != 0);
                if (m_wait && (q.size() == 0 || (q.size() == 1 && dec_valid && dec_ready))) begin
                    if ($urandom_range(2, 0) == 0) begin
                        br_done = 1'b1;
                        br_taken = 1'($urandom);
                        model_resolve(br_taken);
                    end
                end else if (!m_wait && $urandom_range(7, 0) == 0) begin
                    br_done = 1'b1;
                    br_taken = 1'($urandom);
                end
                model_fill();
                step();
            end
            sb_en = 1'b0;
            dec_ready = 1'b0;
            br_done = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Reader side of the program ROM interface: owns the program counter, drives the ROM address and reads back 16-bit instructions.
- Splits each instruction into fields and hands it to the execute stage over a valid/ready handshake.
- Resolves unconditional jumps internally.
- Stalls on conditional branches until execute reports the outcome.

Parameters:
ADDR_W, 4, program counter / ROM address width (16-entry ROM)
INST_W, 16, instruction width
RESET_PC, 0, program counter value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rom_addr  out  ADDR_W  ROM address, combinationally equal to pc
rom_data  in  INST_W  instruction returned by ROM for rom_addr (combinational, same cycle)
dec_valid  out  1  decoded instruction register holds a valid instruction
dec_ready  in  1  execute accepts the instruction this cycle when dec_valid high
dec_opcode  out  4  rom_data[15:12]
dec_rd  out  3  rom_data[11:9], destination / out register
dec_rs  out  3  rom_data[8:6], source register
dec_imm  out  8  rom_data[7:0], immediate for load/subi
dec_pc  out  ADDR_W  address the issued instruction was fetched from
br_done  in  1  execute has evaluated the outstanding br (one-cycle pulse)
br_taken  in  1  qualified by br_done: 1 = branch taken

Behaviour:
- Opcodes: 0000 nop, 0001 load, 0010 add, 0011 sub, 1011 subi, 1000 jmp, 1100 br, 1110 mov, 1111 out.
- Jump/branch target is rom_data[11:8].
- Reset (sync, rst=1 at clock edge): pc=RESET_PC, state=RUN, dec_valid=0, all dec_* fields=0.
- Reset overrides everything, including mid-branch-wait and a held unaccepted instruction.
- Slot free = !dec_valid || dec_ready.
- States:
  - RUN: fetching and issuing.
  - BR_WAIT: a br has been issued and its outcome is pending.
- RUN, slot not free: hold pc and all dec_* registers stable. No fetch.
- RUN, slot free, opcode from rom_data:
  - jmp: pc<=target; dec_valid<=0; not issued (1-cycle bubble).
  - nop: pc<=pc+1; dec_valid<=0; not issued.
  - br: issue (dec_valid<=1, fields, dec_pc<=pc); latch target into br_tgt; pc<=pc+1; state<=BR_WAIT.
  - any other opcode (including unlisted codes): issue; pc<=pc+1.
- Issue latency: instruction at pc is presented on dec_* one cycle after the cycle in which it is fetched.
- BR_WAIT: no fetch or issue. dec_valid clears when execute accepts the br.
  - On br_done: pc<=br_tgt if br_taken, else pc is kept (already pc+1); state<=RUN.
  - The first fetch after resolution happens in the cycle after br_done.
- br_done outside BR_WAIT is ignored.
- br_done in the same cycle as acceptance of the br is legal and honored.
- pc arithmetic is modulo 2^ADDR_W: pc=15 wraps to 0 on increment.
- Back-to-back throughput: one instruction per cycle while dec_ready=1 and no jmp/nop/br occurs.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_SUBI, OP_JMP, OP_BR, OP_MOV, OP_OUT);
  - field bit positions (RD_HI/LO, RS_HI/LO, IMM_HI/LO, TGT_HI/LO);
  - state encoding (ST_RUN, ST_BR_WAIT).
- The package is also shared with the execute stage and the assembler-to-ROM tables.
- One combinational sub-module, instr_field_split: rom_data -> opcode/rd/rs/imm/target plus is_jmp/is_br/is_nop flags.
- The PC, state machine and output register stay in instr_fetch.

Test Plan:
1. Reset then straight-line program: ROM[0]=0x1201 load r1 1, ROM[1]=0xB401 subi r2 1, dec_ready=1 -> dec_valid rises 1 cycle after rst drops; issues opcode 1/rd 1/imm 0x01/pc 0, then opcode 0xB/rd 2/imm 0x01/pc 1 on consecutive cycles.
2. Backpressure: hold dec_ready=0 for 3 cycles with ROM[0]=0x1E07 -> dec_* stays stable (opcode 1, rd 7, imm 7), rom_addr stays at 1. On dec_ready=1 the next instruction is issued the following cycle.
3. Jump: ROM[6]=0x8300 jmp 3 -> not issued; rom_addr=3 on the next cycle; exactly one bubble (dec_valid=0) on dec_*.
4. Branch: ROM[4]=0xCA00 br 10.
   - Issued with dec_pc=4; then no fetch for 5 idle cycles.
   - br_done=1, br_taken=1 -> rom_addr=10 next cycle; ROM[10]=0xF200 out r1 issued with rd=1.
   - Repeat with br_taken=0 -> fetch resumes at 5.
5. Wrap and nop: ROM[14]=0x0000, ROM[15]=0xFE00, ROM[0]=0x1201 -> address 14 not issued; 15 issued (out r7); pc wraps to 0 and load r1 issued with dec_pc=0.
6. Reset mid-operation: assert rst in BR_WAIT with dec_valid=1 -> next cycle dec_valid=0, rom_addr=0, state RUN. A late br_done pulse after reset is ignored and causes no pc change.
